// File: rtl/imem_loader.sv
// imem_loader: serial program loader that owns the imem write port during a framed load and holds the CPU in reset
module imem_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 50000,
  parameter int         TO_W      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [7:0] pc,
  output logic [7:0] imem_addr,
  output logic       imem_we,
  output logic [7:0] imem_wdata,
  output logic       cpu_reset,
  output logic       busy,
  output logic       load_done,
  output logic       load_err
);
  typedef enum logic [2:0] {RUN, LEN, DATA, CSUM, ERR} state_t;
  state_t state;
  logic [7:0] wr_addr, csum;
  logic [8:0] count;
  logic [TO_W-1:0] timer;
  logic active;
  assign active = (state == LEN) || (state == DATA) || (state == CSUM);
  // a write still in flight keeps the port even after the FSM has moved on
  assign busy = active | imem_we;
  assign imem_addr = busy ? wr_addr : pc;
  assign cpu_reset = reset | (state != RUN);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      imem_we <= 1'b0;
      imem_wdata <= 8'h00;
      wr_addr <= 8'h00;
      load_done <= 1'b0;
      load_err <= 1'b0;
      csum <= 8'h00;
      count <= 9'd0;
      timer <= '0;
    end else begin
      imem_we <= 1'b0;
      load_done <= 1'b0;
      if (imem_we) wr_addr <= wr_addr + 8'd1;
      timer <= (active && !rx_valid) ? timer + 1'b1 : '0;
      if (!active) begin
        if (rx_valid && rx_data == SYNC_BYTE) state <= LEN;
      end else if (rx_valid) begin
        if (state == LEN) begin
          count <= {rx_data == 8'd0, rx_data};
          wr_addr <= 8'h00;
          csum <= 8'h00;
          state <= DATA;
        end else if (state == DATA) begin
          imem_we <= 1'b1;
          imem_wdata <= rx_data;
          csum <= csum + rx_data;
          count <= count - 9'd1;
          if (count == 9'd1) state <= CSUM;
        end else if (rx_data == csum) begin
          state <= RUN;
          load_done <= 1'b1;
          load_err <= 1'b0;
        end else begin
          state <= ERR;
          load_err <= 1'b1;
        end
      end else if (timer == TO_W'(TIMEOUT - 1)) begin
        state <= ERR;
        load_err <= 1'b1;
      end
    end
  end
endmodule
